seed_ct_unload: RTL

Ciphertext unload stage at the output end of the SEED Feistel datapath, the counterpart of the right-half loader that feeds the F function. It counts qualified round-sync events and captures the final-round halves after round 15. It then presents the 128-bit ciphertext with a valid/ready handshake and flags sequencing errors and lost blocks. It sits between the round XOR logic / right-half hold register and the host-side output interface.

---
 rtl/seed_pkg.sv | 26 ++
 rtl/seed_ct_skid2.sv | 73 +++++++
 rtl/seed_ct_unload.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/seed_pkg.sv
// Shared definitions for the SEED ciphertext unload stage: datapath widths,
// round count, the output-side state encoding and a round-counter helper.
package seed_pkg;

    localparam int         SEED_HALF_W   = 64;
    localparam int         SEED_ROUNDS   = 16;
    localparam logic [3:0] SEED_LAST_RND = 4'd15;

    // Output holding register: empty, or holding a ciphertext not yet accepted
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ct_state_e;

    // Advance the round counter, wrapping after the last round of a block
    function automatic logic [3:0] next_round(input logic [3:0] cnt, input logic [3:0] last);
        logic [3:0] nxt;
        if (cnt == last) begin
            nxt = 4'd0;
        end else begin
            nxt = cnt + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/seed_ct_skid2.sv
// Two-entry valid/ready buffer placed between ciphertext capture and the host
// output. Entry 0 is always the head presented on the output; entry 1 holds
// a second ciphertext captured while the head is still waiting. FIFO order.
module seed_ct_skid2
    import seed_pkg::*;
#(
    parameter int DATA_W = 2 * SEED_HALF_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready
);

    logic [1:0]        r_cnt;
    logic [DATA_W-1:0] r_e0;
    logic [DATA_W-1:0] r_e1;
    logic              w_push;
    logic              w_pop;

    // A full buffer can still take a new entry when the head leaves this cycle
    assign o_ready = (r_cnt != 2'd2) | i_ready;
    assign w_push  = i_valid & o_ready;
    assign w_pop   = i_ready & (r_cnt != 2'd0);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_e0;

    // Entry storage and occupancy; entry 1 shifts into entry 0 on a pop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 2'd0;
            r_e0  <= '0;
            r_e1  <= '0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (w_push) begin
                        r_e0  <= i_data;
                        r_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_e0 <= i_data;
                    end else if (w_pop) begin
                        r_cnt <= 2'd0;
                    end else if (w_push) begin
                        r_e1  <= i_data;
                        r_cnt <= 2'd2;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_e0 <= r_e1;
                        if (w_push) begin
                            r_e1 <= i_data;
                        end else begin
                            r_cnt <= 2'd1;
                        end
                    end
                end
                default: begin
                    r_cnt <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/seed_ct_unload.sv
// SEED ciphertext unload stage. Counts qualified round-sync events, captures
// {xor_in, hold_in} after the last round and presents the 128-bit ciphertext
// on a valid/ready interface, with sticky sequencing and overflow flags.
// Build option: SEED_CT_SKID_EN adds a two-entry output buffer (seed_ct_skid2)
// so one extra block can wait while the host stalls.
module seed_ct_unload
    import seed_pkg::*;
#(
    parameter int HALF_W   = SEED_HALF_W,
    parameter int N_ROUNDS = SEED_ROUNDS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clk_en,
    input  logic                start_f,
    input  logic                sync,
    input  logic [3:0]          Rounds,
    input  logic [HALF_W-1:0]   xor_in,
    input  logic [HALF_W-1:0]   hold_in,
    input  logic                ct_ready,
    output logic                ct_valid,
    output logic [2*HALF_W-1:0] ct_data,
    output logic                busy,
    output logic                seq_err,
    output logic                ovf_err
);

    localparam logic [3:0] LAST_RND = 4'(N_ROUNDS - 1);

    logic [3:0]          r_rnd_cnt;
    logic                r_seq_err;
    logic                r_ovf_err;
    logic                w_qev;
    logic                w_capture;
    logic                w_ovf_set;
    logic [2*HALF_W-1:0] w_cap_data;

    assign w_qev      = clk_en & start_f & sync;
    assign w_capture  = w_qev & (r_rnd_cnt == LAST_RND);
    // Final round is taken without the Feistel swap
    assign w_cap_data = {xor_in, hold_in};

    assign busy    = (r_rnd_cnt != 4'd0);
    assign seq_err = r_seq_err;
    assign ovf_err = r_ovf_err;

    // Round counter: cleared whenever start_f is low, advances on each qualified event
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rnd_cnt <= 4'd0;
        end else if (!start_f) begin
            r_rnd_cnt <= 4'd0;
        end else if (w_qev) begin
            r_rnd_cnt <= next_round(r_rnd_cnt, LAST_RND);
        end
    end

    // Sticky sequence error: round control disagreed with our own count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seq_err <= 1'b0;
        end else if (w_qev && (Rounds != r_rnd_cnt)) begin
            r_seq_err <= 1'b1;
        end
    end

    // Sticky overflow error: a captured block had nowhere to go
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf_err <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf_err <= 1'b1;
        end
    end

`ifdef SEED_CT_SKID_EN
    logic w_skid_in_ready;

    seed_ct_skid2 #(
        .DATA_W (2 * HALF_W)
    ) u_skid (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_valid (w_capture),
        .i_data  (w_cap_data),
        .o_ready (w_skid_in_ready),
        .o_valid (ct_valid),
        .o_data  (ct_data),
        .i_ready (ct_ready)
    );

    assign w_ovf_set = w_capture & ~w_skid_in_ready;
`else
    ct_state_e           r_state;
    ct_state_e           w_state_nxt;
    logic                w_load;
    logic [2*HALF_W-1:0] r_ct_data;

    // Output FSM next state: load on capture unless a stalled block is still held
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ovf_set   = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_capture) begin
                    w_load      = 1'b1;
                    w_state_nxt = FULL;
                end else begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_capture) begin
                    if (ct_ready) begin
                        w_load = 1'b1;
                    end else begin
                        w_ovf_set = 1'b1;
                    end
                    w_state_nxt = FULL;
                end else if (ct_ready) begin
                    w_state_nxt = EMPTY;
                end else begin
                    w_state_nxt = FULL;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    // Output FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ciphertext holding register, only written when a block is accepted into it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ct_data <= '0;
        end else if (w_load) begin
            r_ct_data <= w_cap_data;
        end
    end

    assign ct_valid = (r_state == FULL);
    assign ct_data  = r_ct_data;
`endif

endmodule
